led_refresh_scheduler: RTL and testbench

Sequences and shares the `led_controller` frame engine between several requesters, e.g. the register view, the panel-button view and the diagnostics view. Each requester owns a full cell array. The scheduler picks a requester round-robin and drives the select of an external cell-array mux. It then opens a short snapshot window (`ctrl_refresh_lock` low) and issues one `ctrl_refresh` pulse. A guard interval follows so that the next frame cannot start before the previous WS2812 transfer and latch gap have finished. When nobody asks, it issues a periodic auto-refresh of the current source.

---
 rtl/led_refresh_scheduler.sv | 118 +++++++++++
 tb/tb_led_refresh_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/led_refresh_scheduler.sv
// Round-robin scheduler that shares one led_controller frame engine between
// several cell-array requesters, with guard spacing and idle auto-refresh.
module led_refresh_scheduler #(
  parameter int NUM_REQ            = 4,
  parameter int MIN_FRAME_CYCLES   = 500000,
  parameter int AUTO_PERIOD_CYCLES = 5000000,
  parameter int LOCK_WINDOW        = 4,
  localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic [SW-1:0]      sel,
  output logic               ctrl_refresh,
  output logic               ctrl_refresh_lock,
  output logic [15:0]        frame_count
);
  localparam int GW = (MIN_FRAME_CYCLES > 1) ? $clog2(MIN_FRAME_CYCLES) : 1;
  localparam int AW = (AUTO_PERIOD_CYCLES > 0) ? $clog2(AUTO_PERIOD_CYCLES + 1) : 1;
  localparam int LW = $clog2(LOCK_WINDOW);

  typedef enum logic [1:0] {IDLE, SETTLE, FIRE, GUARD} state_t;

  state_t        state, state_n;
  logic [SW-1:0] winner, last_grant, pick, hi_idx, lo_idx;
  logic          auto_flag, auto_due, any_req, hi_found, lo_found;
  logic [AW-1:0] auto_cnt;
  logic [GW-1:0] guard_cnt;
  logic [LW-1:0] lock_cnt;

  // Round-robin: first requester above the last grant wins, else wrap to the lowest.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req[j]) begin
        if (j > int'(last_grant)) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_idx   = SW'(j);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = SW'(j);
        end
      end
    end
    any_req = hi_found | lo_found;
    pick    = hi_found ? hi_idx : lo_idx;
  end

  assign auto_due = (AUTO_PERIOD_CYCLES != 0) && (auto_cnt >= AW'(AUTO_PERIOD_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req || auto_due) state_n = SETTLE;
      SETTLE:  state_n = FIRE;
      FIRE:    state_n = GUARD;
      GUARD:   if (guard_cnt == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sel         <= '0;
      winner      <= '0;
      last_grant  <= SW'(NUM_REQ - 1);
      auto_flag   <= 1'b0;
      auto_cnt    <= '0;
      guard_cnt   <= '0;
      lock_cnt    <= '0;
      frame_count <= '0;
    end else begin
      if (state == FIRE)                           auto_cnt <= '0;
      else if (auto_cnt != AW'(AUTO_PERIOD_CYCLES)) auto_cnt <= auto_cnt + AW'(1);
      case (state)
        IDLE: begin
          if (any_req) begin
            sel       <= pick;
            winner    <= pick;
            auto_flag <= 1'b0;
          end else if (auto_due) begin
            auto_flag <= 1'b1;
          end
        end
        FIRE: begin
          if (!auto_flag) last_grant <= winner;
          frame_count <= frame_count + 16'd1;
          lock_cnt    <= LW'(LOCK_WINDOW - 1);
          guard_cnt   <= GW'(MIN_FRAME_CYCLES - 1);
        end
        GUARD: begin
          if (lock_cnt != '0)  lock_cnt  <= lock_cnt - LW'(1);
          if (guard_cnt != '0) guard_cnt <= guard_cnt - GW'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from registered state only; req never reaches them combinationally.
  always_comb begin
    ctrl_refresh      = (state == FIRE);
    ctrl_refresh_lock = !((state == FIRE) || ((state == GUARD) && (lock_cnt != '0)));
    for (int i = 0; i < NUM_REQ; i++)
      ack[i] = (state == FIRE) && !auto_flag && (winner == SW'(i));
  end
endmodule

// File: tb/tb_led_refresh_scheduler.sv
// Bench for led_refresh_scheduler: per-cycle vector table plus a FIRE scoreboard
// fed by the stimulus and drained by a negedge monitor.
module tb_led_refresh_scheduler;
  logic        clk, rst;
  logic [3:0]  req, ack;
  logic [1:0]  sel;
  logic        ctrl_refresh, ctrl_refresh_lock;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  led_refresh_scheduler #(
    .NUM_REQ(4), .MIN_FRAME_CYCLES(16), .AUTO_PERIOD_CYCLES(64), .LOCK_WINDOW(4)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .sel(sel),
    .ctrl_refresh(ctrl_refresh), .ctrl_refresh_lock(ctrl_refresh_lock),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc is the cycle index since reset release (0 = first cycle with rst high).
  always @(posedge clk) cyc <= rst ? cyc + 1 : 0;

  typedef struct {
    int         cyc;
    logic [3:0] req;
    logic [1:0] sel;
    logic [3:0] ack;
    logic       refresh;
    logic       lock;
    logic [15:0] fc;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [1:0]  sel;
    logic [3:0]  ack;
    logic [15:0] fc;
  } fire_t;

  fire_t exp_q[$];
  fire_t mon_e;
  vec_t  vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic drained(input string nm);
    chk({nm, "_pending_fires"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Every FIRE must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b1 && ctrl_refresh === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fire: cyc %0d sel %0d ack %b expected no fire", cyc, sel, ack);
      end else begin
        mon_e = exp_q.pop_front();
        chk("fire_cyc", cyc, mon_e.cyc);
        chk("fire_sel", sel, mon_e.sel);
        chk("fire_ack", ack, mon_e.ack);
        chk("fire_lock", ctrl_refresh_lock, 0);
        chk("fire_count", frame_count, mon_e.fc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    req = '0;

    // Single request: reset state, SETTLE/FIRE timing, lock window.
    vecs[0] = '{0,  4'b0000, 2'd0, 4'b0000, 1'b0, 1'b1, 16'd0};
    vecs[1] = '{9,  4'b0000, 2'd0, 4'b0000, 1'b0, 1'b1, 16'd0};
    vecs[2] = '{10, 4'b0100, 2'd0, 4'b0000, 1'b0, 1'b1, 16'd0};
    vecs[3] = '{11, 4'b0100, 2'd2, 4'b0000, 1'b0, 1'b1, 16'd0};
    vecs[4] = '{12, 4'b0000, 2'd2, 4'b0100, 1'b1, 1'b0, 16'd0};
    vecs[5] = '{13, 4'b0000, 2'd2, 4'b0000, 1'b0, 1'b0, 16'd1};
    vecs[6] = '{15, 4'b0000, 2'd2, 4'b0000, 1'b0, 1'b0, 16'd1};
    vecs[7] = '{16, 4'b0000, 2'd2, 4'b0000, 1'b0, 1'b1, 16'd1};
    vecs[8] = '{28, 4'b0000, 2'd2, 4'b0000, 1'b0, 1'b1, 16'd1};
    vecs[9] = '{29, 4'b0000, 2'd2, 4'b0000, 1'b0, 1'b1, 16'd1};

    do_reset();
    for (int k = 0; k < 10; k++) begin
      wait_cyc(vecs[k].cyc);
      req = vecs[k].req;
      if (vecs[k].cyc == 10) exp_q.push_back('{12, 2'd2, 4'b0100, 16'd0});
      @(negedge clk);
      chk($sformatf("vec%0d_sel", k), sel, vecs[k].sel);
      chk($sformatf("vec%0d_ack", k), ack, vecs[k].ack);
      chk($sformatf("vec%0d_refresh", k), ctrl_refresh, vecs[k].refresh);
      chk($sformatf("vec%0d_lock", k), ctrl_refresh_lock, vecs[k].lock);
      chk($sformatf("vec%0d_count", k), frame_count, vecs[k].fc);
    end
    wait_cyc(40);
    drained("single");

    // Round-robin under continuous requests: 0,1,2,3,0 spaced 19 apart.
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++)
      exp_q.push_back('{2 + 19 * g, 2'(g % 4), 4'(1 << (g % 4)), 16'(g)});
    wait_cyc(80);
    req = '0;
    wait_cyc(100);
    drained("round_robin");

    // Auto-refresh every 67 cycles; a request coinciding with the threshold wins.
    do_reset();
    exp_q.push_back('{66,  2'd0, 4'b0000, 16'd0});
    exp_q.push_back('{133, 2'd0, 4'b0000, 16'd1});
    exp_q.push_back('{200, 2'd0, 4'b0000, 16'd2});
    exp_q.push_back('{267, 2'd1, 4'b0010, 16'd3});
    exp_q.push_back('{334, 2'd1, 4'b0000, 16'd4});
    wait_cyc(265);
    req = 4'b0010;
    wait_cyc(267);
    req = '0;
    wait_cyc(340);
    drained("auto");

    // Requests during GUARD: a 1-cycle pulse is lost, a held level is served after GUARD.
    do_reset();
    exp_q.push_back('{2,  2'd0, 4'b0001, 16'd0});
    exp_q.push_back('{21, 2'd1, 4'b0010, 16'd1});
    req = 4'b0001;
    wait_cyc(2);
    req = '0;
    for (int c = 3; c <= 18; c++) begin
      wait_cyc(c);
      req = (c == 5 || c >= 10) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      chk($sformatf("guard_sel_c%0d", c), sel, 0);
    end
    wait_cyc(21);
    req = '0;
    wait_cyc(40);
    drained("guard_req");

    // Reset in the middle of GUARD.
    do_reset();
    exp_q.push_back('{2,  2'd0, 4'b0001, 16'd0});
    exp_q.push_back('{21, 2'd1, 4'b0010, 16'd1});
    req = 4'b1111;
    wait_cyc(25);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_lock", ctrl_refresh_lock, 1);
    chk("midrst_count", frame_count, 0);
    chk("midrst_sel", sel, 0);
    chk("midrst_refresh", ctrl_refresh, 0);
    exp_q.push_back('{2, 2'd0, 4'b0001, 16'd0});
    wait_cyc(2);
    req = '0;
    wait_cyc(30);
    drained("mid_reset");

    // Request dropped during SETTLE is still served.
    do_reset();
    exp_q.push_back('{7, 2'd3, 4'b1000, 16'd0});
    wait_cyc(5);
    req = 4'b1000;
    wait_cyc(6);
    req = '0;
    wait_cyc(30);
    drained("settle_drop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
